window_row_sequencer: RTL and testbench
=======================================

// Module: window_row_sequencer
// PURPOSE
//   Central sequencer for the 5x5 sliding-window datapath (x window -> five row buffers -> y window).
//   Tracks pixel column/row within a frame and drives the one-hot row-buffer write select (asel).
//   Drives the vertical rotation index (hsel) and the line/frame boundary strobes.
//   Qualifies which pixel strobes produce a fully-populated 5-row window, so downstream filters
//   ignore the priming rows.
// PARAMETERS
//   WIDTH   420  active pixels per line
//   HEIGHT  240  active lines per frame
//   XW      9    x_count width; must satisfy 2**XW >= WIDTH
//   YW      9    y_count width; must satisfy 2**YW >= HEIGHT
// PORTS
//   clock         in   1   single system clock; all logic is posedge
//   reset         in   1   synchronous, active-high
//   validin       in   1   pixel strobe; all counting qualified by it
//   sof           in   1   start of frame; sampled only when validin=1; marks the pixel at x=0,y=0
//   asel          out  5   one-hot row-buffer write select
//   hsel          out  3   y-window rotation index, 0..4
//   x_count       out  XW  column of the next expected pixel
//   y_count       out  YW  row of the next expected pixel
//   line_end      out  1   one-cycle pulse after the last pixel of a line
//   frame_end     out  1   one-cycle pulse after the last pixel of a frame
//   window_valid  out  1   registered; a full 5-row window exists for the pixel accepted last cycle
//   err_sof       out  1   sticky flag: sof arrived mid-frame
// BEHAVIOUR
//   Reset values: asel=5'b00001, hsel=0, x_count=0, y_count=0, all pulse outputs=0, err_sof=0, state=IDLE.
//     Reset takes priority over all other inputs in any state.
//   FSM states: IDLE (wait for frame), PRIME (rows 0..3), RUN (rows 4..HEIGHT-1).
//   IDLE:
//     validin without sof is ignored; counters hold.
//     validin&sof accepts the pixel as (0,0): x_count<=1, asel<=00001, hsel<=0, y_count<=0, goto PRIME.
//   PRIME/RUN, per accepted pixel (validin=1):
//     x_count<=x_count+1.
//     At x_count==WIDTH-1: x_count<=0; y_count<=y_count+1; line_end<=1.
//       asel rotates 00001->00010->00100->01000->10000->00001.
//       A non-one-hot asel recovers to 00001 at this boundary.
//       hsel increments, wrapping 4->0.
//   PRIME->RUN: at the line end of row 3 (y_count==3).
//   Frame end: at x_count==WIDTH-1 and y_count==HEIGHT-1:
//     frame_end<=1 (same cycle as line_end); y_count<=0; goto IDLE. asel/hsel keep their rotated values.
//   sof with validin in PRIME/RUN:
//     err_sof<=1 (cleared only by reset).
//     The pixel is taken as (0,0): x_count<=1, y_count<=0, asel<=00001, hsel<=0, goto PRIME.
//     sof takes priority over a simultaneous line/frame end; line_end and frame_end stay 0.
//   sof with validin=0: ignored in all states.
//   window_valid(t+1) = validin(t) & (state(t)==RUN) [& column mask, see CONFIGURATION]; latency 1 cycle.
//   line_end, frame_end, window_valid: 0 on every cycle with no qualifying event; never held.
//   Gaps in validin freeze all counters, asel, hsel and state.
// CONFIGURATION
//   BORDER_MASK_EN defined:
//     window_valid additionally requires x_count(t)>=4, masking the columns the x window has not yet filled.
//   BORDER_MASK_EN undefined:
//     No column mask; window_valid covers every RUN pixel.
// TESTING
//   1 Reset mid-RUN at x=5,y=4 -> next cycle: asel=00001, hsel=0, x=y=0, window_valid=0, state IDLE; err_sof unchanged.
//   2 WIDTH=8,HEIGHT=6, sof + 48 contiguous validin:
//       6 line_end pulses; asel 00010,00100,01000,10000,00001,00010; hsel 1,2,3,4,0,1.
//       1 frame_end, coincident with the 6th line_end.
//   3 Same frame -> 16 window_valid pulses (rows 4-5) without the macro; 8 pulses with BORDER_MASK_EN.
//   4 Same frame with validin toggling every other cycle -> identical pulse counts and sequences;
//       no counter moves on validin=0 cycles.
//   5 sof+validin at x=3,y=2 -> next cycle: x=1, y=0, asel=00001, hsel=0, err_sof=1 and held through following frames.
//   6 IDLE, 10 validin with sof=0 -> x=y=0, no pulses; a following sof starts counting normally.

Source files
------------

// File: rtl/window_row_sequencer.sv
// Column/row sequencer for the 5x5 sliding-window datapath: row-buffer select, rotation index, boundary strobes.
// Optional BORDER_MASK_EN: window_valid also masks the first four columns of each line.
module window_row_sequencer #(
    parameter int WIDTH  = 420,
    parameter int HEIGHT = 240,
    parameter int XW     = 9,
    parameter int YW     = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          validin,
    input  logic          sof,
    output logic [4:0]    asel,
    output logic [2:0]    hsel,
    output logic [XW-1:0] x_count,
    output logic [YW-1:0] y_count,
    output logic          line_end,
    output logic          frame_end,
    output logic          window_valid,
    output logic          err_sof
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    asel_q, asel_d;
    logic [2:0]    hsel_q, hsel_d;
    logic [XW-1:0] x_count_q, x_count_d;
    logic [YW-1:0] y_count_q, y_count_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;
    logic          window_valid_q, window_valid_d;
    logic          err_sof_q, err_sof_d;

    logic          x_last, y_last, asel_onehot;

    assign x_last      = (x_count_q == XW'(WIDTH - 1));
    assign y_last      = (y_count_q == YW'(HEIGHT - 1));
    assign asel_onehot = (asel_q != 5'b0) && ((asel_q & (asel_q - 5'd1)) == 5'b0);

    always_comb begin
        state_d        = state_q;
        asel_d         = asel_q;
        hsel_d         = hsel_q;
        x_count_d      = x_count_q;
        y_count_d      = y_count_q;
        line_end_d     = 1'b0;
        frame_end_d    = 1'b0;
        err_sof_d      = err_sof_q;
`ifdef BORDER_MASK_EN
        window_valid_d = validin && (state_q == RUN) && (x_count_q >= XW'(4));
`else
        window_valid_d = validin && (state_q == RUN);
`endif

        if (validin) begin
            if (sof) begin
                // sof always restarts at (0,0); mid-frame it also wins over any boundary
                if (state_q != IDLE)
                    err_sof_d = 1'b1;
                x_count_d = XW'(1);
                y_count_d = '0;
                asel_d    = 5'b00001;
                hsel_d    = 3'd0;
                state_d   = PRIME;
            end else if (state_q != IDLE) begin
                if (x_last) begin
                    x_count_d  = '0;
                    line_end_d = 1'b1;
                    asel_d     = asel_onehot ? {asel_q[3:0], asel_q[4]} : 5'b00001;
                    hsel_d     = (hsel_q == 3'd4) ? 3'd0 : hsel_q + 3'd1;
                    if (y_last) begin
                        y_count_d   = '0;
                        frame_end_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        y_count_d = y_count_q + YW'(1);
                        if (state_q == PRIME && y_count_q == YW'(3))
                            state_d = RUN;
                    end
                end else begin
                    x_count_d = x_count_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            asel_q         <= 5'b00001;
            hsel_q         <= 3'd0;
            x_count_q      <= '0;
            y_count_q      <= '0;
            line_end_q     <= 1'b0;
            frame_end_q    <= 1'b0;
            window_valid_q <= 1'b0;
            err_sof_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            asel_q         <= asel_d;
            hsel_q         <= hsel_d;
            x_count_q      <= x_count_d;
            y_count_q      <= y_count_d;
            line_end_q     <= line_end_d;
            frame_end_q    <= frame_end_d;
            window_valid_q <= window_valid_d;
            err_sof_q      <= err_sof_d;
        end
    end

    assign asel         = asel_q;
    assign hsel         = hsel_q;
    assign x_count      = x_count_q;
    assign y_count      = y_count_q;
    assign line_end     = line_end_q;
    assign frame_end    = frame_end_q;
    assign window_valid = window_valid_q;
    assign err_sof      = err_sof_q;

endmodule

// File: tb/tb_window_row_sequencer.sv
// Directed bench for window_row_sequencer on a small 8x6 frame.
module tb_window_row_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = 9;
    localparam int YW = 9;
`ifdef BORDER_MASK_EN
    localparam int EXP_WV = 8;
`else
    localparam int EXP_WV = 16;
`endif
    localparam logic [29:0] EXP_ASEL = {5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
    localparam logic [17:0] EXP_HSEL = {3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          validin = 1'b0;
    logic          sof = 1'b0;
    logic [4:0]    asel;
    logic [2:0]    hsel;
    logic [XW-1:0] x_count;
    logic [YW-1:0] y_count;
    logic          line_end, frame_end, window_valid, err_sof;

    int tests = 0;
    int fails = 0;

    window_row_sequencer #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset(reset), .validin(validin), .sof(sof),
        .asel(asel), .hsel(hsel), .x_count(x_count), .y_count(y_count),
        .line_end(line_end), .frame_end(frame_end),
        .window_valid(window_valid), .err_sof(err_sof)
    );

    always #5 clock = ~clock;

    // drive, take one edge, then observe 1 time unit after it
    task automatic step(input logic v, input logic s);
        validin = v;
        sof = s;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        reset = 1'b0;
        chk("reset_asel", 32'(asel), 32'h1);
        chk("reset_hsel", 32'(hsel), 32'h0);
        chk("reset_xy", {16'(x_count), 16'(y_count)}, 32'h0);
        chk("reset_pulses", {28'h0, line_end, frame_end, window_valid, err_sof}, 32'h0);
    endtask

    // one 48-pixel frame from IDLE; optional idle gap after each pixel
    task automatic run_frame(input string tag, input bit toggle);
        int le_n = 0, fe_n = 0, wv_n = 0, fe_bad = 0, gap_bad = 0;
        logic [29:0] aseq = '0;
        logic [17:0] hseq = '0;
        logic [XW-1:0] xs;
        logic [YW-1:0] ys;
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, (i == 0));
            if (line_end) begin
                le_n++;
                aseq = {aseq[24:0], asel};
                hseq = {hseq[14:0], hsel};
            end
            if (frame_end) begin
                fe_n++;
                if (!line_end || le_n != 6) fe_bad++;
            end
            if (window_valid) wv_n++;
            if (toggle) begin
                xs = x_count;
                ys = y_count;
                step(1'b0, 1'b1);
                if (x_count !== xs || y_count !== ys || line_end || frame_end || window_valid)
                    gap_bad++;
            end
        end
        chk({tag, "_line_end_count"}, 32'(le_n), 32'd6);
        chk({tag, "_asel_seq"}, 32'(aseq), 32'(EXP_ASEL));
        chk({tag, "_hsel_seq"}, 32'(hseq), 32'(EXP_HSEL));
        chk({tag, "_frame_end_count"}, 32'(fe_n), 32'd1);
        chk({tag, "_frame_end_coincident"}, 32'(fe_bad), 32'd0);
        chk({tag, "_window_valid_count"}, 32'(wv_n), 32'(EXP_WV));
        chk({tag, "_end_xy"}, {16'(x_count), 16'(y_count)}, 32'h0);
        if (toggle) chk({tag, "_gap_frozen"}, 32'(gap_bad), 32'd0);
        // back in IDLE: a stray pixel without sof must not count
        step(1'b1, 1'b0);
        chk({tag, "_idle_after"}, 32'(x_count), 32'd0);
    endtask

    task automatic test_frame();
        run_frame("contig", 1'b0);
    endtask

    task automatic test_toggle();
        run_frame("toggle", 1'b1);
    endtask

    task automatic test_reset_mid_run();
        step(1'b1, 1'b1);
        for (int i = 0; i < 36; i++) step(1'b1, 1'b0);
        chk("midrun_xy", {16'(x_count), 16'(y_count)}, {16'd5, 16'd4});
        chk("midrun_wv", 32'(window_valid), 32'd1);
        reset = 1'b1;
        step(1'b1, 1'b0);
        reset = 1'b0;
        chk("rst_mid_asel_hsel", {24'(asel), 8'(hsel)}, {24'h1, 8'h0});
        chk("rst_mid_xy", {16'(x_count), 16'(y_count)}, 32'h0);
        chk("rst_mid_wv_err", {30'h0, window_valid, err_sof}, 32'h0);
    endtask

    task automatic test_idle_ignore();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (line_end || frame_end || window_valid) pulses++;
        end
        chk("idle_xy", {16'(x_count), 16'(y_count)}, 32'h0);
        chk("idle_pulses", 32'(pulses), 32'd0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("idle_then_sof_x", 32'(x_count), 32'd2);
        chk("idle_then_sof_err", 32'(err_sof), 32'd0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_sof_mid_frame();
        step(1'b1, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
        chk("sof_pre_xy", {16'(x_count), 16'(y_count)}, {16'd3, 16'd2});
        step(1'b1, 1'b1);
        chk("sof_mid_xy", {16'(x_count), 16'(y_count)}, {16'd1, 16'd0});
        chk("sof_mid_sel", {24'(asel), 8'(hsel)}, {24'h1, 8'h0});
        chk("sof_mid_err", 32'(err_sof), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        chk("sof_pre_edge_x", 32'(x_count), 32'd7);
        step(1'b1, 1'b1);
        chk("sof_at_edge_pulses", {30'h0, line_end, frame_end}, 32'h0);
        chk("sof_at_edge_x", 32'(x_count), 32'd1);
        step(1'b0, 1'b1);
        chk("sof_novalid_ignored", 32'(x_count), 32'd1);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        // err was cleared by reset above; set it again and carry it through a full frame
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run_frame("errframe", 1'b0);
        chk("err_sticky", 32'(err_sof), 32'd1);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        chk("err_cleared_by_reset", 32'(err_sof), 32'd0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_toggle();
        test_reset_mid_run();
        test_idle_ignore();
        test_sof_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
